// File: rtl/mipi_rx_pkg.sv
// mipi_rx_pkg: lane states, LP line encodings and counter widths for the D-PHY RX lane controller
package mipi_rx_pkg;
    typedef enum logic [2:0] {STOP, HS_RQST, HS_PREP, HS_SETTLE, HS_RX, ESC_WAIT} lane_state_t;
    localparam logic [1:0] LP00 = 2'b00;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP10 = 2'b10;
    localparam logic [1:0] LP11 = 2'b11;
    localparam int SET_W = 8;
    localparam int TO_W = 10;
endpackage

// File: rtl/mipi_rx_lane_fsm.sv
// mipi_rx_lane_fsm: one D-PHY data lane -- LP synchroniser, HS entry/exit FSM, settle and timeout counters
module mipi_rx_lane_fsm
    import mipi_rx_pkg::*;
#(
    parameter int SETTLE_CYC = 6,
    parameter int TO_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lp_p,
    input  logic lp_n,
    input  logic hs_dis,
    output logic hs_sel,
    output logic hs_valid,
    output logic err_esc,
    output logic err_to
);
    logic [1:0] p_sync, n_sync, lp;
    lane_state_t st, nxt;
    logic [SET_W-1:0] set_cnt;
    logic [TO_W-1:0] to_cnt;
    logic l11, l11_q, exit2, counting, expire, settled;
    logic sel_d, valid_d, esc_d, to_d;

    assign lp = {p_sync[1], n_sync[1]};
    assign l11 = lp == LP11;
    assign exit2 = l11 && l11_q;
    assign counting = st == HS_RQST || st == HS_PREP;
    assign expire = counting && to_cnt >= TO_W'(TO_CYC - 1);
    assign settled = set_cnt >= SET_W'(SETTLE_CYC - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_sync   <= '1;
            n_sync   <= '1;
            l11_q    <= 1'b1;
            st       <= STOP;
            set_cnt  <= '0;
            to_cnt   <= '0;
            hs_sel   <= 1'b0;
            hs_valid <= 1'b0;
            err_esc  <= 1'b0;
            err_to   <= 1'b0;
        end else begin
            p_sync   <= {p_sync[0], lp_p};
            n_sync   <= {n_sync[0], lp_n};
            l11_q    <= l11;
            st       <= nxt;
            set_cnt  <= (hs_dis || st != HS_SETTLE) ? '0 : &set_cnt ? set_cnt : set_cnt + SET_W'(1);
            to_cnt   <= (hs_dis || !counting) ? '0 : &to_cnt ? to_cnt : to_cnt + TO_W'(1);
            hs_sel   <= sel_d;
            hs_valid <= valid_d;
            err_esc  <= esc_d;
            err_to   <= to_d;
        end
    end

    // LP-11 exits beat a coinciding timeout; hs_dis overrides everything
    always_comb begin
        nxt = st;
        case (st)
            STOP:      nxt = lp == LP01 ? HS_RQST : lp == LP10 ? ESC_WAIT : STOP;
            HS_RQST:   nxt = (l11 || expire) ? STOP : lp == LP00 ? HS_PREP : lp == LP10 ? ESC_WAIT : HS_RQST;
            HS_PREP:   nxt = (l11 || expire) ? STOP : HS_SETTLE;
            HS_SETTLE: nxt = exit2 ? STOP : settled ? HS_RX : HS_SETTLE;
            HS_RX:     nxt = exit2 ? STOP : HS_RX;
            ESC_WAIT:  nxt = l11 ? STOP : ESC_WAIT;
            default:   nxt = STOP;
        endcase
        if (hs_dis) nxt = STOP;
    end

    always_comb begin
        sel_d   = nxt == HS_SETTLE || nxt == HS_RX;
        valid_d = nxt == HS_RX;
        esc_d   = !hs_dis && lp == LP10 && (st == STOP || (st == HS_RQST && !expire));
        to_d    = !hs_dis && expire && !l11;
    end
endmodule

// File: rtl/mipi_rx_lane_ctrl.sv
// mipi_rx_lane_ctrl: LANES independent D-PHY RX lane controllers plus an all-lanes-valid flag
module mipi_rx_lane_ctrl
    import mipi_rx_pkg::*;
#(
    parameter int LANES = 2,
    parameter int SETTLE_CYC = 6,
    parameter int TO_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [LANES-1:0] lp_p,
    input  logic [LANES-1:0] lp_n,
    input  logic hs_dis,
    output logic [LANES-1:0] hs_sel,
    output logic [LANES-1:0] hs_valid,
    output logic hs_all,
    output logic [LANES-1:0] err_esc,
    output logic [LANES-1:0] err_to
);
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mipi_rx_lane_fsm #(.SETTLE_CYC(SETTLE_CYC), .TO_CYC(TO_CYC)) u_lane (
            .clk(clk),
            .rst_n(rst_n),
            .lp_p(lp_p[g]),
            .lp_n(lp_n[g]),
            .hs_dis(hs_dis),
            .hs_sel(hs_sel[g]),
            .hs_valid(hs_valid[g]),
            .err_esc(err_esc[g]),
            .err_to(err_to[g])
        );
    end

    assign hs_all = &hs_valid;
endmodule

// File: tb/tb_mipi_rx_lane_ctrl.sv
// tb_mipi_rx_lane_ctrl: directed checks of HS entry/exit, escape error, timeout, hs_dis and reset
module tb_mipi_rx_lane_ctrl;
    localparam logic [1:0] L00 = 2'b00;
    localparam logic [1:0] L01 = 2'b01;
    localparam logic [1:0] L10 = 2'b10;
    localparam logic [1:0] L11 = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hs_dis = 1'b0;
    logic [1:0] lp_p = 2'b11;
    logic [1:0] lp_n = 2'b11;
    logic [1:0] hs_sel, hs_valid, err_esc, err_to;
    logic hs_all;
    int total = 0;
    int bad = 0;
    int n_to, at;
    logic seen;

    always #5 clk = ~clk;

    mipi_rx_lane_ctrl #(.LANES(2), .SETTLE_CYC(6), .TO_CYC(64)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .lp_p(lp_p),
        .lp_n(lp_n),
        .hs_dis(hs_dis),
        .hs_sel(hs_sel),
        .hs_valid(hs_valid),
        .hs_all(hs_all),
        .err_esc(err_esc),
        .err_to(err_to)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] l0, input logic [1:0] l1);
        lp_p = {l1[1], l0[1]};
        lp_n = {l1[0], l0[0]};
    endtask

    // 2 sync cycles + RQST + PREP: hs_sel rises 4 edges after LP00 is applied
    task automatic enter(input logic [1:0] m);
        drive(L11, L11);
        step(4);
        drive(m[0] ? L01 : L11, m[1] ? L01 : L11);
        step(4);
        drive(m[0] ? L00 : L11, m[1] ? L00 : L11);
        step(3);
        chk("prep_sel", hs_sel, 0);
        step(1);
        chk("settle_sel", hs_sel, m);
    endtask

    task automatic to_rx(input logic [1:0] m);
        step(5);
        chk("settle_valid", hs_valid, 0);
        step(1);
        chk("rx_valid", hs_valid, m);
        chk("rx_all", hs_all, &m);
    endtask

    initial begin
        step(2);
        chk("rst_sel", hs_sel, 0);
        chk("rst_valid", hs_valid, 0);
        chk("rst_esc", err_esc, 0);
        chk("rst_to", err_to, 0);
        chk("rst_all", hs_all, 0);
        rst_n = 1'b1;
        step(4);

        enter(2'b01);
        to_rx(2'b01);
        drive(L11, L11);
        step(3);
        chk("rx_hold_sel", hs_sel, 2'b01);
        step(1);
        chk("exit_sel", hs_sel, 0);
        chk("exit_valid", hs_valid, 0);

        enter(2'b11);
        to_rx(2'b11);
        drive(L11, L00);
        step(1);
        drive(L00, L00);
        step(5);
        chk("glitch_valid", hs_valid, 2'b11);
        drive(L11, L11);
        step(3);
        chk("all_hold", hs_all, 1);
        step(1);
        chk("all_exit_sel", hs_sel, 0);
        chk("all_exit_valid", hs_valid, 0);
        chk("all_exit_all", hs_all, 0);
        step(2);

        drive(L10, L11);
        step(2);
        chk("esc_pre", err_esc, 0);
        step(1);
        chk("esc_pulse", err_esc, 2'b01);
        step(1);
        chk("esc_clear", err_esc, 0);
        drive(L01, L11);
        step(4);
        drive(L00, L11);
        step(6);
        chk("esc_hold_sel", hs_sel, 0);
        chk("esc_no_more", err_esc, 0);
        drive(L11, L11);
        step(4);
        enter(2'b01);
        drive(L11, L11);
        step(5);

        drive(L01, L11);
        n_to = 0;
        at = 0;
        seen = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            step(1);
            if (err_to[0]) begin
                n_to++;
                at = i;
            end
            seen |= hs_sel[0] | err_to[1];
        end
        chk("to_count", n_to, 1);
        chk("to_cycle", at, 67);
        chk("to_no_sel", seen, 0);
        drive(L11, L11);
        step(4);

        drive(L01, L11);
        step(64);
        drive(L11, L11);
        n_to = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            n_to += int'(err_to[0]);
        end
        chk("to_vs_lp11", n_to, 0);

        enter(2'b11);
        to_rx(2'b11);
        hs_dis = 1'b1;
        step(1);
        chk("dis_sel", hs_sel, 0);
        chk("dis_valid", hs_valid, 0);
        chk("dis_err", {err_esc, err_to}, 0);
        drive(L10, L10);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            seen |= |{err_esc, err_to, hs_sel};
        end
        chk("dis_hold", seen, 0);
        drive(L11, L11);
        step(3);
        hs_dis = 1'b0;
        step(1);
        enter(2'b11);
        to_rx(2'b11);
        drive(L11, L11);
        step(5);

        enter(2'b11);
        step(2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel", hs_sel, 0);
        chk("async_rst_valid", hs_valid, 0);
        drive(L00, L00);
        step(3);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            seen |= |{hs_sel, err_esc, err_to};
        end
        chk("rst_lp00_stop", seen, 0);
        enter(2'b11);
        to_rx(2'b11);
        drive(L11, L11);
        step(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mipi_rx_lane_ctrl.md
MIPI_RX_LANE_CTRL -- requirements
Module: mipi_rx_lane_ctrl

Interface
REQ-001 SHALL have parameter LANES, default 2, number of D-PHY data lanes (range 1..4).
REQ-002 SHALL have parameter SETTLE_CYC, default 6, clk cycles spent in HS_SETTLE with hs_sel high before HS data is declared valid (range 1..255).
REQ-003 SHALL have parameter TO_CYC, default 64, maximum clk cycles allowed in LP-01 or LP-00 before timeout (range 4..1023).
REQ-004 SHALL have port clk, input, 1, single system clock; all logic in this domain.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port lp_p, input, LANES, per-lane LP receiver Dp, asynchronous to clk, valid in both modes.
REQ-007 SHALL have port lp_n, input, LANES, per-lane LP receiver Dn, asynchronous to clk, valid in both modes.
REQ-008 SHALL have port hs_dis, input, 1, force all lanes to STOP and deassert hs_sel.
REQ-009 SHALL have port hs_sel, output, LANES, per-lane HS/LP buffer select; 1 selects HS.
REQ-010 SHALL have port hs_valid, output, LANES, per-lane HS data valid.
REQ-011 SHALL have port hs_all, output, 1, AND of hs_valid over all lanes.
REQ-012 SHALL have port err_esc, output, LANES, one-cycle pulse on an unsupported escape entry (LP-10 from STOP).
REQ-013 SHALL have port err_to, output, LANES, one-cycle pulse on a request/prepare timeout.

Function
REQ-014 SHALL synchronise each lp_p/lp_n bit through two flops; the "LP state" is {lp_p_sync, lp_n_sync}, 2 cycles of input latency.
REQ-015 SHALL run one independent FSM per lane, states STOP, HS_RQST, HS_PREP, HS_SETTLE, HS_RX, ESC_WAIT.
REQ-016 STOP: LP-01 -> HS_RQST; LP-10 -> ESC_WAIT with err_esc pulse; LP-00 or LP-11 -> stay.
REQ-017 HS_RQST: LP-00 -> HS_PREP; LP-11 -> STOP; LP-10 -> ESC_WAIT with err_esc pulse.
REQ-018 HS_PREP: on entry hs_sel SHALL rise on the next clk and the state SHALL advance to HS_SETTLE; LP-11 before that edge -> STOP.
REQ-019 HS_SETTLE: hs_sel=1; 8-bit counter counts SETTLE_CYC cycles, then -> HS_RX; LP-11 on 2 consecutive samples -> STOP.
REQ-020 HS_RX: hs_sel=1, hs_valid=1; LP-11 on 2 consecutive samples -> STOP, with hs_sel and hs_valid low in the cycle STOP is entered.
REQ-021 ESC_WAIT: hs_sel=0; LP-11 -> STOP; all other LP states hold.
REQ-022 A 10-bit per-lane timeout counter SHALL clear on entry to HS_RQST, count in HS_RQST/HS_PREP, and on reaching TO_CYC SHALL return the lane to STOP with a one-cycle err_to pulse.
REQ-023 hs_dis=1 SHALL, on the next edge, force every lane to STOP with hs_sel, hs_valid and counters cleared and no error pulse; it SHALL hold lanes in STOP while asserted.
REQ-024 If timeout expiry and an LP-11 exit coincide, the lane SHALL go to STOP and err_to SHALL NOT pulse.
REQ-025 hs_sel, hs_valid, err_esc and err_to SHALL be registered outputs; hs_all SHALL be combinational from registered hs_valid.
REQ-026 Counters SHALL saturate, never wrap.

Reset
REQ-027 rst_n low SHALL asynchronously set every lane to STOP, synchroniser flops to 1 (LP-11), counters to 0, and all outputs to 0.
REQ-028 Reset removal SHALL require LP-11 to reach the synchronised LP state before any lane leaves STOP; reset asserted mid-HS SHALL drop hs_sel immediately.

Structure
REQ-029 Package mipi_rx_pkg SHALL hold the lane-state enum, LP-state encodings (LP00/LP01/LP10/LP11) and counter widths.
REQ-030 Sub-module mipi_rx_lane_fsm SHALL implement one lane (sync, FSM, counters) and SHALL be instantiated LANES times by a generate loop; the top adds only hs_all.

Verification
REQ-031 LANES=2, lane0 driven LP11->LP01->LP00 each held 4 cycles -> hs_sel[0]=1 one cycle after HS_PREP is entered, hs_valid[0]=1 six cycles later; lane1 stays 0.
REQ-032 Both lanes run the entry sequence, then LP11 is held 3 cycles -> hs_all=1 during HS_RX, hs_sel=0 and hs_valid=0 after the 2-sample LP-11 qualifier.
REQ-033 LP10 from STOP -> err_esc pulses for exactly 1 cycle, hs_sel stays 0, lane returns to STOP only after LP11.
REQ-034 LP01 held 70 cycles (TO_CYC=64) -> err_to pulses once, lane in STOP, no hs_sel.
REQ-035 hs_dis asserted during HS_RX -> hs_sel=0 next edge, no error pulse; deasserted -> a new entry sequence succeeds.
REQ-036 rst_n pulsed low mid-HS_SETTLE -> all outputs 0 asynchronously; after release with LP00 held, no lane leaves STOP until LP11 then LP01 are seen.
